mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares a single external memory port between the core's instruction-fetch path and its data-access path. It sits between `cpu_core` and the memory subsystem. It accepts independent fetch and load/store requests and serialises them onto one request/acknowledge bus with fixed data-first priority and bounded fetch starvation. It then returns each response to the originating requester as a one-cycle valid pulse.

---
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Ports: clk, rst (async, active-low); if_* fetch side; d_* data side;
//        bus_* registered memory request/ack port.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_valid,
    output logic        bus_req,
    output logic        bus_rw,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    input  logic [63:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t     state, state_nx;
    logic [3:0] streak, streak_nx;
    logic       grant_f, grant_d;
    logic       word_sel;

    // Data wins unless a fetch has waited through SMAX data grants.
    // The streak only counts data grants that overtook a waiting fetch.
    always_comb begin
        state_nx  = state;
        streak_nx = streak;
        grant_f   = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_req && (!if_req || streak < SMAX)) begin
                    grant_d   = 1'b1;
                    state_nx  = DATA;
                    streak_nx = if_req ? streak + 4'd1 : 4'd0;
                end else if (if_req) begin
                    grant_f   = 1'b1;
                    state_nx  = FETCH;
                    streak_nx = 4'd0;
                end
            end
            FETCH, DATA: begin
                if (bus_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= 4'd0;
            bus_req   <= 1'b0;
            bus_rw    <= 1'b0;
            bus_addr  <= 64'd0;
            bus_wdata <= 64'd0;
            word_sel  <= 1'b0;
            if_valid  <= 1'b0;
            if_rdata  <= 32'd0;
            d_valid   <= 1'b0;
            d_rdata   <= 64'd0;
        end else begin
            state    <= state_nx;
            streak   <= streak_nx;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (grant_d) begin
                bus_req   <= 1'b1;
                bus_rw    <= d_rw;
                bus_addr  <= d_addr;
                bus_wdata <= d_wdata;
            end else if (grant_f) begin
                bus_req   <= 1'b1;
                bus_rw    <= 1'b0;
                bus_addr  <= if_addr;
                bus_wdata <= 64'd0;
                word_sel  <= if_addr[2];
            end else if (state != IDLE && bus_ack) begin
                bus_req <= 1'b0;
                if (state == FETCH) begin
                    if_valid <= 1'b1;
                    if_rdata <= word_sel ? bus_rdata[63:32]
                                         : bus_rdata[31:0];
                end else begin
                    d_valid <= 1'b1;
                    d_rdata <= bus_rw ? 64'd0 : bus_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized traffic compared against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_rw;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_valid;
    logic        bus_req;
    logic        bus_rw;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [63:0] bus_rdata;
    logic        bus_ack;

    int   passes = 0;
    int   fails  = 0;
    int   total  = 0;
    int   streak = 0;
    logic got_d;

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
        .bus_req(bus_req), .bus_rw(bus_rw), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".bus_req"}, 64'(bus_req), 64'd0);
        chk({tag, ".bus_rw"}, 64'(bus_rw), 64'd0);
        chk({tag, ".bus_addr"}, bus_addr, 64'd0);
        chk({tag, ".bus_wdata"}, bus_wdata, 64'd0);
        chk({tag, ".if_valid"}, 64'(if_valid), 64'd0);
        chk({tag, ".if_rdata"}, 64'(if_rdata), 64'd0);
        chk({tag, ".d_valid"}, 64'(d_valid), 64'd0);
        chk({tag, ".d_rdata"}, d_rdata, 64'd0);
    endtask

    // One complete transaction starting from IDLE with current inputs.
    // The model picks the winner from the arbitration rules, then the
    // bench plays memory with the given ack latency.
    task automatic do_txn(input int lat, input logic [63:0] rd,
                          input bit drop, output logic was_d);
        logic        ed;
        logic [63:0] ea, ew, er;
        logic        erw;
        if (d_req && !if_req) begin
            ed = 1'b1; streak = 0;
        end else if (if_req && !d_req) begin
            ed = 1'b0; streak = 0;
        end else if (streak < SM) begin
            ed = 1'b1; streak++;
        end else begin
            ed = 1'b0; streak = 0;
        end
        ea  = ed ? d_addr : if_addr;
        erw = ed ? d_rw : 1'b0;
        ew  = ed ? d_wdata : 64'd0;
        if (ed) er = d_rw ? 64'd0 : rd;
        else er = if_addr[2] ? {32'd0, rd[63:32]} : {32'd0, rd[31:0]};
        tick();
        chk("grant.bus_req", 64'(bus_req), 64'd1);
        chk("grant.bus_addr", bus_addr, ea);
        chk("grant.bus_rw", 64'(bus_rw), 64'(erw));
        chk("grant.bus_wdata", bus_wdata, ew);
        chk("grant.no_valid", 64'({if_valid, d_valid}), 64'd0);
        if (drop) begin
            if_req = 1'b0;
            d_req  = 1'b0;
        end
        for (int i = 1; i < lat; i++) begin
            tick();
            chk("wait.bus_req", 64'(bus_req), 64'd1);
            chk("wait.bus_addr", bus_addr, ea);
            chk("wait.bus_wdata", bus_wdata, ew);
            chk("wait.bus_rw", 64'(bus_rw), 64'(erw));
            chk("wait.no_valid", 64'({if_valid, d_valid}), 64'd0);
        end
        bus_ack   = 1'b1;
        bus_rdata = rd;
        tick();
        bus_ack   = 1'b0;
        bus_rdata = {$urandom(), $urandom()};
        chk("resp.bus_req", 64'(bus_req), 64'd0);
        chk("resp.if_valid", 64'(if_valid), 64'(!ed));
        chk("resp.d_valid", 64'(d_valid), 64'(ed));
        if (ed) chk("resp.d_rdata", d_rdata, er);
        else chk("resp.if_rdata", 64'(if_rdata), er);
        was_d = ed;
    endtask

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = 64'd0;
        d_req     = 1'b0;
        d_rw      = 1'b0;
        d_addr    = 64'd0;
        d_wdata   = 64'd0;
        bus_rdata = 64'd0;
        bus_ack   = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        #2 rst = 1'b1;

        // single read
        d_req  = 1'b1;
        d_addr = 64'h1000;
        do_txn(1, 64'hDEADBEEF_CAFEF00D, 1'b0, got_d);
        d_req = 1'b0;
        chk("read.d_rdata", d_rdata, 64'hDEADBEEF_CAFEF00D);
        tick();
        chk("read.pulse_end", 64'({if_valid, d_valid, bus_req}), 64'd0);

        // fetch word select, both halves
        if_req  = 1'b1;
        if_addr = 64'h2004;
        do_txn(1, 64'h11112222_33334444, 1'b0, got_d);
        chk("fetch_hi", 64'(if_rdata), 64'h11112222);
        if_addr = 64'h2000;
        do_txn(1, 64'h11112222_33334444, 1'b0, got_d);
        chk("fetch_lo", 64'(if_rdata), 64'h33334444);
        if_req = 1'b0;
        tick();

        // starvation bound: D,D,D,D,F repeating
        if_req  = 1'b1;
        if_addr = 64'h3000;
        d_req   = 1'b1;
        d_rw    = 1'b0;
        d_addr  = 64'h4000;
        for (int i = 0; i < 10; i++) begin
            do_txn(1, {$urandom(), $urandom()}, 1'b0, got_d);
            chk("starve.order", 64'(got_d), 64'((i % 5) != 4));
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();

        // slow write
        d_req   = 1'b1;
        d_rw    = 1'b1;
        d_addr  = 64'h5008;
        d_wdata = 64'hA5A5A5A5_A5A5A5A5;
        do_txn(6, 64'hFFFF0000_FFFF0000, 1'b0, got_d);
        d_req = 1'b0;
        d_rw  = 1'b0;
        tick();
        chk("write.after", 64'({bus_req, d_valid}), 64'd0);

        // abandoned fetch
        if_req  = 1'b1;
        if_addr = 64'h6004;
        do_txn(3, 64'h01234567_89ABCDEF, 1'b1, got_d);
        tick();
        chk("abandon.idle", 64'({bus_req, if_valid}), 64'd0);

        // reset mid-transaction, then ignored ack and fresh grant
        d_req  = 1'b1;
        d_addr = 64'h7000;
        tick();
        chk("rstmid.bus_req", 64'(bus_req), 64'd1);
        #2 rst = 1'b0;
        #1 chk_all_zero("rstmid");
        d_req = 1'b0;
        tick();
        bus_ack   = 1'b1;
        bus_rdata = 64'h55;
        #2 rst = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("rstmid.ack_ignored", 64'({if_valid, d_valid, bus_req}), 64'd0);
        streak = 0;
        d_req  = 1'b1;
        d_addr = 64'h7008;
        do_txn(2, 64'h0BADF00D_0BADF00D, 1'b0, got_d);
        d_req = 1'b0;

        // randomized traffic; pending requests are held until served
        for (int n = 0; n < 80; n++) begin
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req  = 1'b1;
                if_addr = {$urandom(), $urandom()};
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req   = 1'b1;
                d_rw    = 1'($urandom_range(0, 1));
                d_addr  = {$urandom(), $urandom()};
                d_wdata = {$urandom(), $urandom()};
            end
            if (!if_req && !d_req) begin
                bus_ack = 1'($urandom_range(0, 1));
                tick();
                bus_ack = 1'b0;
                chk("rand.idle", 64'({bus_req, if_valid, d_valid}), 64'd0);
            end else begin
                do_txn(int'($urandom_range(1, 4)), {$urandom(), $urandom()},
                       1'b0, got_d);
                if (got_d) d_req = 1'b0;
                else if_req = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
